muller_array: RTL and testbench

MULLER_ARRAY -- requirements
Module: muller_array

---
 rtl/muller_array.sv | 126 ++++++++++++
 tb/tb_muller_array.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muller_array.sv
// -----------------------------------------------------------------------------
// muller_array
//
// Purpose:
//   A bank of CHANNELS independent, clocked Muller C-elements. Each channel
//   has SIZE inputs and works as follows:
//     - Its output goes to 1 when all of its sampled inputs are 1.
//     - Its output goes to 0 when all of its sampled inputs are 0.
//     - Its output holds when the sampled inputs are mixed.
//   Each channel also has a saturating counter of output transitions.
//
// Optional feature (macro MULLER_ARRAY_SYNC_EN):
//   When the macro is defined, every data_in bit passes through a 2-flop
//   synchronizer before it is evaluated. This makes the latency from
//   data_in to data_out 3 clock edges.
//   When the macro is undefined, data_in is evaluated directly with a
//   latency of 1 edge, and no synchronizer flops exist.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   data_in    CHANNELS*SIZE bits; channel c uses bits [c*SIZE +: SIZE]
//   cnt_clr    synchronous clear of all transition counters
//   data_out   registered C-element state, one bit per channel
//   all_high   1 when every data_out bit is 1
//   all_low    1 when every data_out bit is 0
//   trans_cnt  CHANNELS*CNT_W bits; channel c counter in [c*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module muller_array #(
  parameter int SIZE     = 2,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*SIZE-1:0]  data_in,
  input  logic                      cnt_clr,
  output logic [CHANNELS-1:0]       data_out,
  output logic                      all_high,
  output logic                      all_low,
  output logic [CHANNELS*CNT_W-1:0] trans_cnt
);

  localparam int N_IN = CHANNELS * SIZE;

  // Inputs as seen by the C-element evaluation logic.
  logic [N_IN-1:0] eval_in;

`ifdef MULLER_ARRAY_SYNC_EN
  logic [N_IN-1:0] sync1_q;
  logic [N_IN-1:0] sync1_d;
  logic [N_IN-1:0] sync2_q;
  logic [N_IN-1:0] sync2_d;

  always_comb begin
    sync1_d = data_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign eval_in = sync2_q;
`else
  assign eval_in = data_in;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SIZE-1:0]  in_c;
      logic             out_q;
      logic             out_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             trans;

      assign in_c = eval_in[gi*SIZE +: SIZE];

      always_comb begin
        out_d = out_q;
        if (&in_c) begin
          out_d = 1'b1;
        end else if (~|in_c) begin
          out_d = 1'b0;
        end
        trans = out_d ^ out_q;

        // A clear on the same edge as a transition still records that
        // transition, so the counter lands on 1 rather than 0.
        cnt_d = cnt_q;
        if (cnt_clr) begin
          cnt_d = trans ? CNT_W'(1) : '0;
        end else if (trans && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          out_q <= out_d;
          cnt_q <= cnt_d;
        end
      end

      assign data_out[gi]                    = out_q;
      assign trans_cnt[gi*CNT_W +: CNT_W]    = cnt_q;
    end
  endgenerate

  // Both flags are decoded from registered state. They are therefore
  // mutually exclusive for CHANNELS >= 1.
  assign all_high = &data_out;
  assign all_low  = ~|data_out;

endmodule

// File: tb/tb_muller_array.sv
// -----------------------------------------------------------------------------
// tb_muller_array
//
// Purpose:
//   Self-checking bench for muller_array, using SIZE=2, CHANNELS=4, CNT_W=4.
//   A behavioural per-channel model counts the ones on each channel and
//   decides set/clear/hold. It keeps integer counters that saturate at
//   2^CNT_W-1. Every edge is checked against this model.
//
// Stimulus:
//   - Directed sequences.
//   - An asynchronous reset pulse between clock edges.
//   - Randomized traffic.
// -----------------------------------------------------------------------------
module tb_muller_array;

  localparam int SIZE = 2;
  localparam int CH   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cnt_clr;
  logic [CH*SIZE-1:0] data_in;
  logic [CH-1:0]      data_out;
  logic               all_high;
  logic               all_low;
  logic [CH*CW-1:0]   trans_cnt;

  muller_array #(.SIZE(SIZE), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .cnt_clr   (cnt_clr),
    .data_out  (data_out),
    .all_high  (all_high),
    .all_low   (all_low),
    .trans_cnt (trans_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_out [CH];
  int m_cnt [CH];
  logic [CH*SIZE-1:0] m_p1, m_p2;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_out[c] = 0;
      m_cnt[c] = 0;
    end
    m_p1 = '0;
    m_p2 = '0;
  endtask

  task automatic model_edge(input logic [CH*SIZE-1:0] din, input logic clr);
    logic [CH*SIZE-1:0] ev;
`ifdef MULLER_ARRAY_SYNC_EN
    ev   = m_p2;
    m_p2 = m_p1;
    m_p1 = din;
`else
    ev = din;
`endif
    for (int c = 0; c < CH; c++) begin
      int ones;
      int nv;
      ones = 0;
      for (int k = 0; k < SIZE; k++) ones += int'(ev[c*SIZE+k]);
      if (ones == SIZE)   nv = 1;
      else if (ones == 0) nv = 0;
      else                nv = m_out[c];
      if (clr) m_cnt[c] = (nv != m_out[c]) ? 1 : 0;
      else if (nv != m_out[c] && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
      m_out[c] = nv;
    end
  endtask

  task automatic check_all(input string tag);
    logic [CH-1:0]    e_out;
    logic [CH*CW-1:0] e_cnt;
    for (int c = 0; c < CH; c++) begin
      e_out[c]          = (m_out[c] != 0);
      e_cnt[c*CW +: CW] = CW'(m_cnt[c]);
    end
    check({tag, ".data_out"},  32'(data_out),  32'(e_out));
    check({tag, ".trans_cnt"}, 32'(trans_cnt), 32'(e_cnt));
    check({tag, ".all_high"},  32'(all_high),  32'(&e_out));
    check({tag, ".all_low"},   32'(all_low),   32'(~|e_out));
  endtask

  task automatic step(input string tag, input logic [CH*SIZE-1:0] din, input logic clr);
    @(negedge clk);
    data_in = din;
    cnt_clr = clr;
    @(posedge clk);
    model_edge(din, clr);
    #1;
    check_all(tag);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CH*SIZE-1:0] rnd;
    logic [1:0] seq31 [7];
    logic       exp31 [7];

    rst     = 1'b1;
    data_in = '0;
    cnt_clr = 1'b0;
    model_reset();
    #12;
    check("reset.data_out",  32'(data_out),  32'h0);
    check("reset.trans_cnt", 32'(trans_cnt), 32'h0);
    check("reset.all_low",   32'(all_low),   32'h1);
    check("reset.all_high",  32'(all_high),  32'h0);
    @(negedge clk);
    rst = 1'b0;

`ifdef MULLER_ARRAY_SYNC_EN
    // Synchronized build: full-ones input appears only on the 3rd edge.
    for (int e = 1; e <= 3; e++) begin
      step("sync_lat", 8'hFF, 1'b0);
      check("sync_lat.edge", 32'(data_out), (e == 3) ? 32'hF : 32'h0);
    end
    step("sync_lat.hold", 8'hFF, 1'b0);
`else
    // Channel 0 walks through every input combination.
    seq31 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
    exp31 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step("ch0_seq", {6'b0, seq31[i]}, 1'b0);
      check("ch0_seq.bit", 32'(data_out[0]), 32'(exp31[i]));
    end
    check("ch0_seq.cnt", 32'(trans_cnt[3:0]), 32'd2);

    // All-ones then all-zeros across the whole array.
    step("all_ff", 8'hFF, 1'b0);
    check("all_ff.out", 32'(data_out), 32'hF);
    check("all_ff.hi",  32'(all_high), 32'h1);
    step("all_00", 8'h00, 1'b0);
    check("all_00.out", 32'(data_out), 32'h0);
    check("all_00.lo",  32'(all_low),  32'h1);

    // Channel 1 toggling drives its counter into saturation.
    step("clr", 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) step("sat", (i % 2 == 0) ? 8'h0C : 8'h00, 1'b0);
    check("sat.cnt", 32'(trans_cnt), 32'h00F0);

    // A clear on the same edge as a 0->1 transition on channel 2.
    step("clr_trans", 8'h30, 1'b1);
    check("clr_trans.cnt", 32'(trans_cnt), 32'h0100);
`endif

    // Asynchronous reset pulse between clock edges.
    step("pre_rst", 8'hFF, 1'b0);
`ifndef MULLER_ARRAY_SYNC_EN
    check("pre_rst.out", 32'(data_out), 32'hF);
`endif
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.out", 32'(data_out),  32'h0);
    check("async_rst.cnt", 32'(trans_cnt), 32'h0);
    check("async_rst.lo",  32'(all_low),   32'h1);
    check("async_rst.hi",  32'(all_high),  32'h0);
    rst = 1'b0;
    model_reset();

    // Randomized traffic, biased so that each channel often sees
    // all-ones or all-zeros.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 3))
          0:       rnd[c*SIZE +: SIZE] = '0;
          1:       rnd[c*SIZE +: SIZE] = '1;
          default: rnd[c*SIZE +: SIZE] = SIZE'($urandom);
        endcase
      end
      step("rand", rnd, ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
